rf_port_arbiter: RTL
====================

# rf_port_arbiter

Sequencer and arbiter that shares one bank of `reg16` registers between two requesters: requester 0 is the CPU execute stage and requester 1 is the debug/load port. It accepts register read/write transactions and grants them round-robin. For the granted transaction it drives the one-hot `ld`, `oeA` and `oeB` enables of the register bank and the shared `Din` write bus. All outputs are registered, and each transaction occupies the bank for exactly one clock.

## Interface
- `NREG`, 8: number of registers in the bank.
- `AW`, 3: register address width; `NREG` = 2^`AW`.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: transaction request from requester 0 and requester 1.
- `we0`, `we1` in 1: transaction includes a write.
- `wa0`, `wa1` in `AW`: write register address.
- `wd0`, `wd1` in 16: write data.
- `ra0`, `ra1` in `AW`: register address for the A read bus.
- `rb0`, `rb1` in `AW`: register address for the B read bus.
- `stall` in 1: blocks new grants while high.
- `gnt0`, `gnt1` out 1: grant strobe, high for the single access cycle.
- `ld` out `NREG`: one-hot load enables to the bank.
- `oeA` out `NREG`: one-hot A-bus output enables.
- `oeB` out `NREG`: one-hot B-bus output enables.
- `Din` out 16: write data to all bank registers.
- `busy` out 1: high when an access cycle is in progress (equals `gnt0 | gnt1`).

## Operation
- **States**
  - IDLE: no access this cycle. All enables are 0 and `gnt*` are 0.
  - ACCESS: exactly one `gnt` is high. `oeA[ra]` and `oeB[rb]` are set one-hot from the captured request. `ld[wa]` is set only if `we` was captured, otherwise `ld` = 0. `Din` = captured write data.
- **Eligibility**: requester i is eligible at an edge if `req_i`=1, `stall`=0, and `gnt_i` is not currently high. A requester's own grant cycle never counts as a new request.
- **Arbitration**: at each edge, if any requester is eligible the next state is ACCESS.
  - One eligible requester: grant it.
  - Both eligible: grant the requester selected by round-robin pointer `rr`.
  - After a grant to requester i, `rr` points to the other requester.
  - If no requester is eligible, the next state is IDLE.
- **Capture**: `we`, `wa`, `wd`, `ra` and `rb` of the winner are captured at the granting edge. Requesters must hold `req` and all fields stable until they see their `gnt`.
- **Reads**: the register bank drives `DA`/`DB` during the ACCESS cycle. The requester samples them at the end of that cycle.
- **Writes**: the register bank loads `Din` at the edge that ends the ACCESS cycle.
- **Same-register read and write** in one transaction: the read returns the old value and the write lands at the end of the cycle.
- **Throughput**: one requester alone gets at most one grant every 2 cycles. Two continuous requesters alternate with no idle cycles.
- **Stall**: asserting `stall` never truncates an ACCESS cycle already in progress. It only suppresses the next grant.
- **Reset**: reset low forces IDLE, `rr`=0 (requester 0 preferred), and `gnt0`=`gnt1`=`busy`=0, `ld`=`oeA`=`oeB`=0, `Din`=0.
  - Reset asserted during ACCESS clears the outputs immediately (asynchronously).
  - The interrupted transaction is dropped; its write does not occur.

## Timing
- Request to grant latency:
  - `req` high at edge N with the requester eligible gives `gnt`/enables high during cycle N..N+1.
  - Read data is valid in that same cycle.
  - The write is committed at edge N+1.
- Every output changes only on the clock edge or on asynchronous reset.
- Invariants:
  - `oeA` and `oeB` are each zero or one-hot.
  - `ld` is zero or one-hot.
  - `gnt0` & `gnt1` is never 1.

## Test plan
- **Reset**: reset low mid-ACCESS (req0, we0=1, wa0=2).
  - `ld`/`oeA`/`oeB`/`gnt*` go to 0 immediately.
  - R2 is unchanged.
  - After release, first contention goes to requester 0.
- **Single write then read**:
  - req0, we0=1, wa0=5, wd0=16'hBEEF → next cycle gnt0=1, `ld`=8'b0010_0000, `Din`=16'hBEEF.
  - Then req0 with ra0=5 → `oeA`=8'b0010_0000 and DA=16'hBEEF.
- **Contention**: req0 and req1 held continuously from reset.
  - Grants go 0,1,0,1 on consecutive cycles with no IDLE cycle.
  - Each granted cycle drives that requester's addresses.
- **Lone requester**: req1 held high continuously → gnt1 pattern 1,0,1,0 and `busy` toggles every cycle.
- **Stall**:
  - `stall`=1 asserted during a gnt0 cycle → that access completes, no further grants while `stall`=1.
  - Pending req1 is granted on the first edge after `stall` drops.
- **Read/write same register**: R3=16'h0001; one transaction with ra0=3, wa0=3, we0=1, wd0=16'h0002.
  - DA=16'h0001 in the grant cycle.
  - A following read returns 16'h0002.

Source files
------------

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing one reg16 bank between the CPU execute stage (0)
// and the debug/load port (1); each grant drives the bank enables for one clock.
module rf_port_arbiter #(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   wa0,
  input  logic [AW-1:0]   wa1,
  input  logic [15:0]     wd0,
  input  logic [15:0]     wd1,
  input  logic [AW-1:0]   ra0,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   rb0,
  input  logic [AW-1:0]   rb1,
  input  logic            stall,
  output logic            gnt0,
  output logic            gnt1,
  output logic [NREG-1:0] ld,
  output logic [NREG-1:0] oeA,
  output logic [NREG-1:0] oeB,
  output logic [15:0]     Din,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

  state_t          state_reg;
  logic            rr_reg;
  logic            elig0;
  logic            elig1;
  logic            pick1;
  logic            win_any;
  logic            we_w;
  logic [AW-1:0]   wa_w;
  logic [AW-1:0]   ra_w;
  logic [AW-1:0]   rb_w;
  logic [15:0]     wd_w;
  logic [NREG-1:0] wa_dec;
  logic [NREG-1:0] ra_dec;
  logic [NREG-1:0] rb_dec;

  // A requester in its own grant cycle is not eligible, so a lone requester
  // is granted at most every other cycle.
  assign elig0   = req0 & ~stall & (state_reg != ACC0);
  assign elig1   = req1 & ~stall & (state_reg != ACC1);
  assign pick1   = elig1 & (~elig0 | rr_reg);
  assign win_any = elig0 | elig1;

  assign we_w = pick1 ? we1 : we0;
  assign wa_w = pick1 ? wa1 : wa0;
  assign ra_w = pick1 ? ra1 : ra0;
  assign rb_w = pick1 ? rb1 : rb0;
  assign wd_w = pick1 ? wd1 : wd0;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
      assign wa_dec[gi] = (wa_w == AW'(gi));
      assign ra_dec[gi] = (ra_w == AW'(gi));
      assign rb_dec[gi] = (rb_w == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      rr_reg    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      ld        <= '0;
      oeA       <= '0;
      oeB       <= '0;
      Din       <= '0;
    end else if (win_any) begin
      state_reg <= pick1 ? ACC1 : ACC0;
      rr_reg    <= ~pick1;
      gnt0      <= ~pick1;
      gnt1      <= pick1;
      busy      <= 1'b1;
      ld        <= we_w ? wa_dec : '0;
      oeA       <= ra_dec;
      oeB       <= rb_dec;
      Din       <= wd_w;
    end else begin
      // Din holds its last value while idle; nothing loads without ld.
      state_reg <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      ld        <= '0;
      oeA       <= '0;
      oeB       <= '0;
    end
  end

endmodule
